dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port registered data RAM (one-cycle read latency) between two requesters.
- Port A is the pipelined core's data port and has priority. Port B is a secondary master (debug/loader/DMA).
- Port A's grant doubles as the core's memory stall: core stalls while a_req=1 and a_gnt=0.
- The block sits between the core's mem_read/mem_write/daddr/ddata_w/ddata_r interface and the RAM instance.

Parameters:
- ADDR_SIZE, 10, word-address width of RAM and both ports
- DATA_SIZE, 32, data width
- STARVE_LIMIT, 8, consecutive cycles B may be denied before it is forced a slot (1..255)
- MAX_BURST, 4, maximum consecutive B beats while b_lock held (1..16)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- a_req  in  1  core access request this cycle
- a_we  in  1  1=write, 0=read
- a_addr  in  ADDR_SIZE  core address
- a_wdata  in  DATA_SIZE  core write data
- a_gnt  out  1  combinational; access accepted this cycle
- a_rvalid  out  1  registered; read data valid, one cycle after a granted read
- a_rdata  out  DATA_SIZE  read data (ddata_r passthrough)
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as the A equivalents, for port B
- b_lock  in  1  B requests back-to-back beats (burst)
- daddr  out  ADDR_SIZE  RAM address
- mem_write  out  1  RAM write enable
- mem_read  out  1  RAM read enable
- ddata_w  out  DATA_SIZE  RAM write data
- ddata_r  in  DATA_SIZE  RAM read data, valid the cycle after mem_read

Behaviour:
- FSM states: ARB (A priority) and BURST (B owns the RAM).
- Grant in ARB:
  - B wins if b_req and (starve_cnt==STARVE_LIMIT or !a_req).
  - Otherwise A wins if a_req.
  - At most one grant per cycle.
- RAM drive: the winner's addr/wdata/we drive daddr/ddata_w/mem_write/mem_read in the same cycle (combinational). With no grant, all four outputs are 0.
- starve_cnt (8 bits):
  - increments each cycle b_req=1 and b_gnt=0, saturating at STARVE_LIMIT
  - clears on any b_gnt, and whenever b_req=0
- Burst entry: a B grant with b_lock=1 moves ARB→BURST and loads beat_cnt=1.
- In BURST:
  - b_gnt = b_req; a_gnt = 0.
  - beat_cnt increments per granted beat.
  - Return to ARB when b_lock=0, b_req=0, or beat_cnt==MAX_BURST after a grant.
  - After exiting on MAX_BURST, A has priority for at least one cycle: starve_cnt is forced to 0.
- Read return: a registered owner tag records the port of a granted read.
  - Next cycle, that port's rvalid=1 and rdata=ddata_r; the other port's rvalid=0.
  - Writes produce no rvalid.
- Back-to-back reads from different ports each get a correct rvalid on consecutive cycles; the owner tag is per-cycle, not sticky.
- Reset values: state=ARB, starve_cnt=0, beat_cnt=0, a_rvalid=b_rvalid=0, owner tag cleared.
  - Combinational outputs follow from reset state: grants purely by request, RAM controls 0 when idle.
- Reset asserted mid-burst: abort to ARB. A read granted in the reset cycle yields no rvalid.
- A request does not need to be held after grant. An ungranted request must be held stable until granted; the arbiter keeps no request queue.
- a_rdata and b_rdata may both show ddata_r; consumers qualify with rvalid.

Decomposition:
- Shared package dmem_arb_pkg:
  - typedef enum {ARB, BURST} arb_state_t
  - typedef enum {OWN_NONE, OWN_A, OWN_B} owner_t
  - localparam widths for starve_cnt and beat_cnt
- One sub-module is natural: dmem_arb_starve_ctr (saturating starvation counter with clear/force-zero).

Test Plan:
- A read only: a_req=1, a_we=0, a_addr=5, RAM[5]=0xDEADBEEF → a_gnt=1, mem_read=1, daddr=5; next cycle a_rvalid=1, a_rdata=0xDEADBEEF, b_rvalid=0.
- Contention: a_req and b_req both held, STARVE_LIMIT=8 → A granted 8 cycles, B granted on cycle 9 (a_gnt=0 that cycle), starve_cnt back to 0.
- Burst: b_lock=1, b_req=1, b_we=1, addrs 0x10..0x13, a_req=1, MAX_BURST=4 → 4 consecutive B writes, a_gnt=0 throughout, then A granted next cycle; RAM[0x10..0x13] hold the written data.
- Interleaved reads: A reads addr 1 (0x11), then B reads addr 2 (0x22) on the next cycle → a_rvalid with 0x11, then b_rvalid with 0x22 on consecutive cycles, never both high.
- Reset mid-burst: RESET=1 during beat 2 → next cycle state=ARB, both rvalid=0, all RAM controls 0 with no requests.
- Idle: no requests → mem_read=mem_write=0, daddr=0, no rvalid, starve_cnt=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and counter widths for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic {ARB, BURST} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;
    localparam int STARVE_W = 8;
    localparam int BEAT_W = 5;
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating count of cycles port B has waited
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != STARVE_W'(LIMIT))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a one-cycle-latency RAM between the core (A, priority) and a secondary master (B)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_SIZE    = 10,
    parameter int DATA_SIZE    = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [DATA_SIZE-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [DATA_SIZE-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [DATA_SIZE-1:0] b_wdata,
    input  logic                 b_lock,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [DATA_SIZE-1:0] b_rdata,
    output logic [ADDR_SIZE-1:0] daddr,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [DATA_SIZE-1:0] ddata_w,
    input  logic [DATA_SIZE-1:0] ddata_r
);
    arb_state_t          state;
    owner_t              owner;
    logic [STARVE_W-1:0] starve_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                b_win;
    logic                max_hit;

    always_comb begin
        b_win     = b_req && (starve_cnt == STARVE_W'(STARVE_LIMIT) || !a_req);
        b_gnt     = (state == BURST) ? b_req : b_win;
        a_gnt     = (state == ARB) && a_req && !b_win;
        daddr     = a_gnt ? a_addr : b_gnt ? b_addr : '0;
        ddata_w   = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
        mem_write = (a_gnt && a_we) || (b_gnt && b_we);
        mem_read  = (a_gnt && !a_we) || (b_gnt && !b_we);
        max_hit   = b_gnt && ((state == BURST) ? (beat_cnt + 1'b1 == BEAT_W'(MAX_BURST))
                                               : (b_lock && MAX_BURST == 1));
        a_rvalid  = owner == OWN_A;
        b_rvalid  = owner == OWN_B;
        a_rdata   = ddata_r;
        b_rdata   = ddata_r;
    end

    dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk(CLK),
        .rst(RESET),
        .inc(b_req && !b_gnt),
        .clr(!b_req || b_gnt || max_hit),
        .cnt(starve_cnt)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ARB;
            beat_cnt <= '0;
            owner    <= OWN_NONE;
        end else begin
            owner <= (a_gnt && !a_we) ? OWN_A : (b_gnt && !b_we) ? OWN_B : OWN_NONE;
            if (state == ARB) begin
                if (b_gnt && b_lock && !max_hit) begin
                    state    <= BURST;
                    beat_cnt <= BEAT_W'(1);
                end
            end else if (!b_req || !b_lock || max_hit) begin
                state    <= ARB;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of priority, starvation, bursts, read return and reset
module tb_dmem_arbiter;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [9:0]  daddr;
    logic        mem_write, mem_read;
    logic [31:0] ddata_w, ddata_r;
    logic [31:0] ram [0:1023];
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_write) ram[daddr] <= ddata_w;
        if (mem_read) ddata_r <= ram[daddr];
    end

    dmem_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .daddr(daddr), .mem_write(mem_write), .mem_read(mem_read),
        .ddata_w(ddata_w), .ddata_r(ddata_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [9:0] aa, input logic [31:0] ad,
                         input logic br, input logic bw, input logic [9:0] ba, input logic [31:0] bd,
                         input logic bl);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        #1;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_starve", dut.starve_cnt, 0);

        tick();
        drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("wr_a_gnt", a_gnt, 1);
        chk("wr_mem_write", mem_write, 1);
        chk("wr_ddata_w", ddata_w, 32'hDEADBEEF);
        tick();
        drive(1, 1, 1, 32'h11, 0, 0, 0, 0, 0);
        chk("wr_no_rvalid", a_rvalid, 0);
        tick();
        drive(1, 1, 2, 32'h22, 0, 0, 0, 0, 0);
        tick();

        drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
        chk("rd_a_gnt", a_gnt, 1);
        chk("rd_mem_read", mem_read, 1);
        chk("rd_mem_write", mem_write, 0);
        chk("rd_daddr", daddr, 5);
        tick();
        idle();
        chk("rd_a_rvalid", a_rvalid, 1);
        chk("rd_a_rdata", a_rdata, 32'hDEADBEEF);
        chk("rd_b_rvalid", b_rvalid, 0);
        tick();

        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("il_a_gnt", a_gnt, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 2, 0, 0);
        chk("il_b_gnt", b_gnt, 1);
        chk("il_b_daddr", daddr, 2);
        chk("il_a_rvalid", a_rvalid, 1);
        chk("il_a_rdata", a_rdata, 32'h11);
        chk("il_b_rvalid0", b_rvalid, 0);
        tick();
        idle();
        chk("il_b_rvalid", b_rvalid, 1);
        chk("il_b_rdata", b_rdata, 32'h22);
        chk("il_a_rvalid0", a_rvalid, 0);
        tick();
        chk("idle_mem_read", mem_read, 0);
        chk("idle_mem_write", mem_write, 0);
        chk("idle_daddr", daddr, 0);
        chk("idle_rvalid", a_rvalid | b_rvalid, 0);
        chk("idle_starve", dut.starve_cnt, 0);

        drive(1, 0, 1, 0, 1, 0, 2, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("ct_starve", dut.starve_cnt, i);
            chk("ct_a_gnt", a_gnt, 1);
            chk("ct_b_gnt", b_gnt, 0);
            tick();
        end
        chk("ct_b_win", b_gnt, 1);
        chk("ct_a_blocked", a_gnt, 0);
        chk("ct_b_daddr", daddr, 2);
        tick();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("ct_starve_clr", dut.starve_cnt, 0);
        chk("ct_a_again", a_gnt, 1);
        chk("ct_b_rvalid", b_rvalid, 1);
        chk("ct_b_rdata", b_rdata, 32'h22);
        tick();
        idle();
        tick();

        drive(1, 0, 1, 0, 1, 1, 10'h10, 32'hB0, 1);
        for (int i = 0; i < 8; i++) begin
            chk("bu_wait_a_gnt", a_gnt, 1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 0, 1, 1, 10'(10'h10 + k), 32'hB0 + k, 1);
            chk("bu_b_gnt", b_gnt, 1);
            chk("bu_a_gnt", a_gnt, 0);
            chk("bu_mem_write", mem_write, 1);
            chk("bu_daddr", daddr, 32'h10 + k);
            tick();
        end
        chk("bu_exit_a_gnt", a_gnt, 1);
        chk("bu_exit_b_gnt", b_gnt, 0);
        chk("bu_exit_starve", dut.starve_cnt, 0);
        idle();
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 10'(10'h10 + k), 0, 0, 0, 0, 0, 0);
            tick();
            idle();
            chk("bu_rb_rvalid", a_rvalid, 1);
            chk("bu_rb_data", a_rdata, 32'hB0 + k);
            tick();
        end

        drive(0, 0, 0, 0, 1, 0, 10'h10, 0, 1);
        chk("mr_beat1", b_gnt, 1);
        tick();
        drive(1, 0, 1, 0, 1, 0, 10'h11, 0, 1);
        chk("mr_beat2_b", b_gnt, 1);
        chk("mr_beat2_a", a_gnt, 0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        idle();
        chk("mr_a_rvalid", a_rvalid, 0);
        chk("mr_b_rvalid", b_rvalid, 0);
        chk("mr_mem_read", mem_read, 0);
        chk("mr_mem_write", mem_write, 0);
        chk("mr_daddr", daddr, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mr_arb_a_gnt", a_gnt, 1);
        tick();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
